// File: rtl/ffd_pkg.sv
// ----------------------------------------------------------------------------
// ffd_pkg
// Shared definitions for the D-flip-flop register family.
//   MODE_HOLD..MODE_DEC : 3-bit operation codes for ffd_universal_reg.mode
//   WIDTH_MIN/WIDTH_MAX : legal register width range
//   width_ok()          : width legality check, reused by future register blocks
// ----------------------------------------------------------------------------
package ffd_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_INC  = 3'b110;
   localparam logic [2:0] MODE_DEC  = 3'b111;

   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 32;

   function automatic bit width_ok(input int unsigned w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/ffd_universal_reg_if.sv
// ----------------------------------------------------------------------------
// ffd_universal_reg_if
// Bus bundle for ffd_universal_reg.
//   enable, mode, D, sin_r, sin_l : control/data into the register
//   Q, sout_l, sout_r, carry, zero : register contents and status out
// master : the block driving the register (datapath controller, testbench)
// slave  : the register itself
// ----------------------------------------------------------------------------
interface ffd_universal_reg_if
   import ffd_pkg::*;
#(
   parameter int WIDTH = 4
);

   logic             enable;
   logic [2:0]       mode;
   logic [WIDTH-1:0] D;
   logic             sin_r;
   logic             sin_l;
   logic [WIDTH-1:0] Q;
   logic             sout_l;
   logic             sout_r;
   logic             carry;
   logic             zero;

   modport master (
      output enable, mode, D, sin_r, sin_l,
      input  Q, sout_l, sout_r, carry, zero
   );

   modport slave (
      input  enable, mode, D, sin_r, sin_l,
      output Q, sout_l, sout_r, carry, zero
   );

endinterface

// File: rtl/ffd_bit.sv
// ----------------------------------------------------------------------------
// ffd_bit
// Single D flip-flop with asynchronous active-low reset to a selectable value
// and a synchronous enable.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   rst_val_i : value taken while rst_n is low (tie to a constant)
//   en_i      : synchronous enable; flop holds when low
//   d_i       : next-state data
//   q_o       : flop output
// ----------------------------------------------------------------------------
module ffd_bit (
   input  logic clk,
   input  logic rst_n,
   input  logic rst_val_i,
   input  logic en_i,
   input  logic d_i,
   output logic q_o
);

   logic q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= rst_val_i;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/ffd_universal_reg.sv
// ----------------------------------------------------------------------------
// ffd_universal_reg
// WIDTH-bit universal register: hold, load, shift left/right with serial in,
// rotate left/right, increment, decrement, with a registered carry/borrow
// flag and combinational zero and serial-out taps.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (Q = RESET_VALUE, carry = 0)
//   bus   : ffd_universal_reg_if.slave
//             enable, mode[2:0], D, sin_r, sin_l in
//             Q, sout_l (Q MSB), sout_r (Q LSB), carry, zero (Q == 0) out
// Parameters
//   WIDTH       : register width, 2..32
//   RESET_VALUE : reset contents, truncated to WIDTH bits
// ----------------------------------------------------------------------------
module ffd_universal_reg
   import ffd_pkg::*;
#(
   parameter int          WIDTH       = 4,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic            clk,
   input  logic            reset,
   ffd_universal_reg_if.slave bus
);

   if (!width_ok(WIDTH)) begin : g_width_err
      $error("ffd_universal_reg: WIDTH=%0d outside legal range 2..32", WIDTH);
   end

   localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             carry_q;
   logic             carry_d;

   // Mode mux. Carry is the bit pushed out of the register by the operation;
   // for INC/DEC it is the extra bit of a WIDTH+1 unsigned add/subtract.
   always_comb begin
      q_d     = q_q;
      carry_d = carry_q;
      case (bus.mode)
         MODE_HOLD: begin
            q_d     = q_q;
            carry_d = carry_q;
         end
         MODE_LOAD: begin
            q_d     = bus.D;
            carry_d = 1'b0;
         end
         MODE_SHL: begin
            q_d     = {q_q[WIDTH-2:0], bus.sin_r};
            carry_d = q_q[WIDTH-1];
         end
         MODE_SHR: begin
            q_d     = {bus.sin_l, q_q[WIDTH-1:1]};
            carry_d = q_q[0];
         end
         MODE_ROL: begin
            q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            carry_d = q_q[WIDTH-1];
         end
         MODE_ROR: begin
            q_d     = {q_q[0], q_q[WIDTH-1:1]};
            carry_d = q_q[0];
         end
         MODE_INC: begin
            {carry_d, q_d} = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
         end
         MODE_DEC: begin
            // Borrow lands in the top bit: only 0 - 1 sets it.
            {carry_d, q_d} = {1'b0, q_q} - {{WIDTH{1'b0}}, 1'b1};
         end
         default: begin
            q_d     = q_q;
            carry_d = carry_q;
         end
      endcase
   end

   // Storage: one flop per Q bit plus one for carry, all sharing the enable.
   for (genvar i = 0; i < WIDTH; i++) begin : g_q
      ffd_bit u_bit (
         .clk       (clk),
         .rst_n     (reset),
         .rst_val_i (RST_V[i]),
         .en_i      (bus.enable),
         .d_i       (q_d[i]),
         .q_o       (q_q[i])
      );
   end

   ffd_bit u_carry (
      .clk       (clk),
      .rst_n     (reset),
      .rst_val_i (1'b0),
      .en_i      (bus.enable),
      .d_i       (carry_d),
      .q_o       (carry_q)
   );

   assign bus.Q      = q_q;
   assign bus.carry  = carry_q;
   assign bus.sout_l = q_q[WIDTH-1];
   assign bus.sout_r = q_q[0];
   assign bus.zero   = (q_q == '0);

   a_mode_known : assert property (
      @(posedge clk) disable iff (!reset) bus.enable |-> !$isunknown(bus.mode)
   );

endmodule

// File: tb/tb_ffd_universal_reg.sv
// ----------------------------------------------------------------------------
// tb_ffd_universal_reg
// Drives three register instances (4-bit reset 0, 4-bit reset 0xA, 8-bit
// reset 0) with identical stimulus and compares every output against an
// arithmetic reference model after each clock and each asynchronous reset.
// ----------------------------------------------------------------------------
module tb_ffd_universal_reg;
   import ffd_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en_s = 1'b0;
   logic [2:0]  mode_s = MODE_HOLD;
   logic [31:0] d_s = '0;
   logic        sr_s = 1'b0;
   logic        sl_s = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ffd_universal_reg_if #(.WIDTH(4)) if4  ();
   ffd_universal_reg_if #(.WIDTH(4)) if4a ();
   ffd_universal_reg_if #(.WIDTH(8)) if8  ();

   assign if4.enable  = en_s;   assign if4a.enable = en_s;   assign if8.enable = en_s;
   assign if4.mode    = mode_s; assign if4a.mode   = mode_s; assign if8.mode   = mode_s;
   assign if4.sin_r   = sr_s;   assign if4a.sin_r  = sr_s;   assign if8.sin_r  = sr_s;
   assign if4.sin_l   = sl_s;   assign if4a.sin_l  = sl_s;   assign if8.sin_l  = sl_s;
   assign if4.D  = d_s[3:0];
   assign if4a.D = d_s[3:0];
   assign if8.D  = d_s[7:0];

   ffd_universal_reg #(.WIDTH(4), .RESET_VALUE(32'h0)) u_dut4 (
      .clk(clk), .reset(reset), .bus(if4));
   ffd_universal_reg #(.WIDTH(4), .RESET_VALUE(32'hA)) u_dut4a (
      .clk(clk), .reset(reset), .bus(if4a));
   ffd_universal_reg #(.WIDTH(8), .RESET_VALUE(32'h0)) u_dut8 (
      .clk(clk), .reset(reset), .bus(if8));

   logic [31:0] obs_q  [3];
   logic        obs_c  [3];
   logic        obs_z  [3];
   logic        obs_sl [3];
   logic        obs_sr [3];

   assign obs_q[0] = {28'b0, if4.Q};
   assign obs_q[1] = {28'b0, if4a.Q};
   assign obs_q[2] = {24'b0, if8.Q};
   assign obs_c[0] = if4.carry;  assign obs_c[1] = if4a.carry;  assign obs_c[2] = if8.carry;
   assign obs_z[0] = if4.zero;   assign obs_z[1] = if4a.zero;   assign obs_z[2] = if8.zero;
   assign obs_sl[0] = if4.sout_l; assign obs_sl[1] = if4a.sout_l; assign obs_sl[2] = if8.sout_l;
   assign obs_sr[0] = if4.sout_r; assign obs_sr[1] = if4a.sout_r; assign obs_sr[2] = if8.sout_r;

   // Reference model
   int          W  [3] = '{4, 4, 8};
   logic [31:0] RV [3] = '{32'h0, 32'hA, 32'h0};
   logic [31:0] mq [3];
   logic        mc [3];

   function automatic logic [31:0] wmask(input int w);
      logic [32:0] m;
      m = (33'd1 << w) - 33'd1;
      return m[31:0];
   endfunction

   // Returns {carry, Q} after one enabled operation, computed with plain
   // unsigned arithmetic on a w-bit value.
   function automatic logic [32:0] model_next(input int w, input logic [2:0] m,
                                              input logic [31:0] q, input logic c,
                                              input logic [31:0] d, input logic sr,
                                              input logic sl);
      logic [31:0] mask;
      logic [31:0] top;
      mask = wmask(w);
      top  = 32'd1 << (w - 1);
      case (m)
         MODE_LOAD: return {1'b0, d & mask};
         MODE_SHL:  return {((q & top) != 0), ((q * 2) + {31'b0, sr}) & mask};
         MODE_SHR:  return {q[0], (q / 2) + (sl ? top : 32'd0)};
         MODE_ROL:  return {((q & top) != 0), ((q * 2) & mask) + ((q & top) != 0 ? 32'd1 : 32'd0)};
         MODE_ROR:  return {q[0], (q / 2) + (q[0] ? top : 32'd0)};
         MODE_INC:  return {(q == mask), (q + 32'd1) & mask};
         MODE_DEC:  return {(q == 32'd0), (q - 32'd1) & mask};
         default:   return {c, q};
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      for (int k = 0; k < 3; k++) begin
         if (!reset) begin
            mq[k] <= RV[k] & wmask(W[k]);
            mc[k] <= 1'b0;
         end else if (en_s) begin
            {mc[k], mq[k]} <= model_next(W[k], mode_s, mq[k], mc[k], d_s, sr_s, sl_s);
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string where);
      for (int k = 0; k < 3; k++) begin
         check_eq($sformatf("%s q[%0d]", where, k), obs_q[k], mq[k]);
         check_eq($sformatf("%s carry[%0d]", where, k), {31'b0, obs_c[k]}, {31'b0, mc[k]});
         check_eq($sformatf("%s zero[%0d]", where, k), {31'b0, obs_z[k]}, {31'b0, (mq[k] == 32'd0)});
         check_eq($sformatf("%s sout_l[%0d]", where, k), {31'b0, obs_sl[k]}, {31'b0, mq[k][W[k]-1]});
         check_eq($sformatf("%s sout_r[%0d]", where, k), {31'b0, obs_sr[k]}, {31'b0, mq[k][0]});
      end
   endtask

   task automatic drive(input logic en, input logic [2:0] m, input logic [31:0] d,
                        input logic sr, input logic sl, input string where);
      @(negedge clk);
      en_s = en; mode_s = m; d_s = d; sr_s = sr; sl_s = sl;
      @(posedge clk);
      #1;
      check_all(where);
   endtask

   // Drops reset a little after a falling edge, checks before the next rising
   // edge, and optionally releases it again while still mid-cycle.
   task automatic async_reset(input bit release_now, input string where);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 check_all(where);
      if (release_now) #1 reset = 1'b1;
   endtask

   logic [3:0] rol_q [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic       rol_c [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
   logic [3:0] cnt_q [5] = '{4'hF, 4'h0, 4'h1, 4'h0, 4'hF};
   logic       cnt_c [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      // Power-on reset
      repeat (2) @(posedge clk);
      #1 check_all("por");
      check_eq("por q rv0", obs_q[0], 32'h0);
      check_eq("por q rvA", obs_q[1], 32'hA);
      @(negedge clk) reset = 1'b1;

      // Asynchronous reset while Q=1011
      drive(1'b1, MODE_LOAD, 32'hB, 1'b0, 1'b0, "load_b");
      check_eq("load_b q", obs_q[0], 32'hB);
      async_reset(1'b0, "async");
      check_eq("async q", obs_q[0], 32'h0);
      check_eq("async carry", {31'b0, obs_c[0]}, 32'h0);
      check_eq("async zero", {31'b0, obs_z[0]}, 32'h1);
      check_eq("async q rvA", obs_q[1], 32'hA);
      @(negedge clk);
      en_s = 1'b0;
      reset = 1'b1;

      // Enable gating
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, MODE_LOAD, 32'h6, 1'b0, 1'b0, "gate_off");
         check_eq("gate_off q", obs_q[0], 32'h0);
      end
      drive(1'b1, MODE_LOAD, 32'h6, 1'b0, 1'b0, "gate_on");
      check_eq("gate_on q", obs_q[0], 32'h6);
      check_eq("gate_on carry", {31'b0, obs_c[0]}, 32'h0);

      // Shifts
      drive(1'b1, MODE_LOAD, 32'h9, 1'b0, 1'b0, "load_9");
      drive(1'b1, MODE_SHL, 32'h0, 1'b1, 1'b0, "shl");
      check_eq("shl q", obs_q[0], 32'h3);
      check_eq("shl carry", {31'b0, obs_c[0]}, 32'h1);
      drive(1'b1, MODE_SHR, 32'h0, 1'b0, 1'b0, "shr");
      check_eq("shr q", obs_q[0], 32'h1);
      check_eq("shr carry", {31'b0, obs_c[0]}, 32'h1);

      // Rotates
      drive(1'b1, MODE_LOAD, 32'h8, 1'b0, 1'b0, "load_8");
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, MODE_ROL, 32'h0, 1'b0, 1'b0, "rol");
         check_eq($sformatf("rol%0d q", i), obs_q[0], {28'b0, rol_q[i]});
         check_eq($sformatf("rol%0d carry", i), {31'b0, obs_c[0]}, {31'b0, rol_c[i]});
      end
      drive(1'b1, MODE_ROR, 32'h0, 1'b0, 1'b0, "ror");
      check_eq("ror q", obs_q[0], 32'h4);
      check_eq("ror carry", {31'b0, obs_c[0]}, 32'h0);

      // Counter wrap
      drive(1'b1, MODE_LOAD, 32'hE, 1'b0, 1'b0, "load_e");
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, (i < 3) ? MODE_INC : MODE_DEC, 32'h0, 1'b0, 1'b0, "count");
         check_eq($sformatf("count%0d q", i), obs_q[0], {28'b0, cnt_q[i]});
         check_eq($sformatf("count%0d carry", i), {31'b0, obs_c[0]}, {31'b0, cnt_c[i]});
      end

      // 8-bit wrap and reset during a counting run
      drive(1'b1, MODE_LOAD, 32'hFF, 1'b0, 1'b0, "w8_load_ff");
      drive(1'b1, MODE_INC, 32'h0, 1'b0, 1'b0, "w8_inc_wrap");
      check_eq("w8 wrap q", obs_q[2], 32'h00);
      check_eq("w8 wrap carry", {31'b0, obs_c[2]}, 32'h1);
      drive(1'b1, MODE_LOAD, 32'h03, 1'b0, 1'b0, "w8_load_3");
      drive(1'b1, MODE_INC, 32'h0, 1'b0, 1'b0, "w8_inc");
      drive(1'b1, MODE_INC, 32'h0, 1'b0, 1'b0, "w8_inc");
      check_eq("w8 run q", obs_q[2], 32'h05);
      async_reset(1'b0, "w8_abort");
      check_eq("w8 abort q", obs_q[2], 32'h00);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, MODE_INC, 32'h0, 1'b0, 1'b0, "w8_held");
         check_eq("w8 held q", obs_q[2], 32'h00);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 check_all("w8_release");
      check_eq("w8 release q", obs_q[2], 32'h01);

      // Randomized operation mix with occasional mid-cycle reset pulses
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            async_reset(1'b1, "rnd_rst");
         end
         drive(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), $urandom,
               1'($urandom), 1'($urandom), "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule

// File: doc/ffd_universal_reg.md
Name: ffd_universal_reg

Overview:
- Parametrised WIDTH-bit register built from D flip-flops. It is the general storage element for the lab datapaths and replaces the fixed 1/2/4-bit D-register modules.
- Adds a synchronous enable qualifier, eight operating modes (hold, load, shifts, rotates, increment, decrement), serial in/out, and carry/zero status.
- Feeds counters, shifters and accumulators in later exercises.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..32; elaboration error outside that range.
- RESET_VALUE, 0, value loaded into Q on reset; truncated to WIDTH bits.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- enable, input, 1, synchronous qualifier; when 0 the register holds regardless of mode.
- mode, input, 3, operation select (encoding below).
- D, input, WIDTH, parallel load data.
- sin_r, input, 1, serial input entering the LSB on shift-left.
- sin_l, input, 1, serial input entering the MSB on shift-right.
- Q, output, WIDTH, register contents.
- sout_l, output, 1, combinational Q[WIDTH-1].
- sout_r, output, 1, combinational Q[0].
- carry, output, 1, registered status flag.
- zero, output, 1, combinational (Q == 0).

Behaviour:
- Reset:
  - reset low: immediately (asynchronously) Q = RESET_VALUE and carry = 0, independent of clk and enable.
  - Release is sampled on the next rising clk. The first operation happens on the first rising edge with reset high.
- Enable:
  - enable is sampled only at the rising clk edge. It never acts as a clock.
  - enable = 0: Q and carry hold. No operation occurs even if mode changes.
- Latency: every operation updates Q and carry at the rising edge where enable = 1. Results are visible one cycle later; there is no internal pipeline.
- Mode encoding and update (enable = 1):
  - 000 HOLD: Q and carry unchanged.
  - 001 LOAD: Q <= D; carry <= 0.
  - 010 SHL: Q <= {Q[WIDTH-2:0], sin_r}; carry <= Q[WIDTH-1].
  - 011 SHR: Q <= {sin_l, Q[WIDTH-1:1]}; carry <= Q[0].
  - 100 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; carry <= Q[WIDTH-1].
  - 101 ROR: Q <= {Q[0], Q[WIDTH-1:1]}; carry <= Q[0].
  - 110 INC: Q <= Q + 1 modulo 2^WIDTH; carry <= 1 only when Q was all ones (wrap to 0), else 0.
  - 111 DEC: Q <= Q - 1 modulo 2^WIDTH; carry (borrow) <= 1 only when Q was 0 (wrap to all ones), else 0.
- Arithmetic is unsigned, WIDTH bits. Carry is the bit lost by the operation; it is never added back in.
- zero, sout_l and sout_r are purely combinational from Q. They follow Q during asynchronous reset.
- Reset during a multi-cycle sequence (e.g. a counting run) aborts it. Q returns to RESET_VALUE with no partial update.
- Unknown or X on mode with enable = 1 is a verification error (assertion). Synthesis treats it as don't-care.

Decomposition:
- Shared package ffd_pkg holds:
  - the mode constants MODE_HOLD..MODE_DEC (3-bit localparams);
  - the width-legality check, reused by future register blocks.
- One sub-module, ffd_bit: a single D flip-flop with clk, active-low asynchronous reset, reset value input, and synchronous enable.
  - The top generates WIDTH instances for Q and one for carry.
  - Next-state logic (mode mux) lives in the top level.

Test Plan (WIDTH=4, RESET_VALUE=0 unless noted):
- Reset: drive reset low mid-cycle while Q=1011 -> Q=0000 and carry=0 before the next clk edge; zero=1. Separately, RESET_VALUE=4'hA -> Q=1010 after reset.
- Enable gating: LOAD D=0110 with enable=0 for 3 edges -> Q stays 0000; raise enable for 1 edge -> Q=0110, carry=0.
- Shifts: Q=1001; SHL with sin_r=1 -> Q=0011, carry=1. Then SHR with sin_l=0 -> Q=0001, carry=1.
- Rotates: Q=1000; ROL 4 edges -> 0001, 0010, 0100, 1000, with carry=1,0,0,0. ROR 1 edge from 1000 -> 0100, carry=0.
- Counter wrap: LOAD 1110, then INC x3 -> Q = 1111 (carry 0), 0000 (carry 1, zero 1), 0001 (carry 0). Then DEC x2 -> 0000 (carry 0), 1111 (carry 1).
- WIDTH=8 regression: LOAD 8'hFF, INC -> Q=8'h00, carry=1. Assert reset during an INC run at Q=8'h05 -> Q=8'h00 with no further count until reset is released.
